// File: rtl/common_pkg.sv
// common_pkg: shared NoC flit types, default widths and credit-counter sizing.
package common_pkg;
  localparam int DEFAULT_VC_W = 2;
  localparam int DEFAULT_A_W = 8;
  localparam int DEFAULT_D_W = 16;
  typedef struct packed {
    logic [DEFAULT_D_W-1:0] data;
    logic                   last;
  } noc_payload_t;
  typedef struct packed {
    logic [DEFAULT_A_W-1:0] addr;
  } noc_routeinfo_t;
  typedef struct packed {
    noc_routeinfo_t routeinfo;
    noc_payload_t   payload;
  } noc_packet_t;
  typedef enum logic {ST_IDLE, ST_LOCKED} arb_state_e;
  function automatic int credit_cnt_w(input int credits);
    return $clog2(credits + 1);
  endfunction
endpackage

// File: rtl/noc_rr_arbiter.sv
// noc_rr_arbiter: masked round-robin arbiter, priority starts just after the last winner.
module noc_rr_arbiter import common_pkg::*; #(
  parameter int N = DEFAULT_VC_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic [N-1:0] mask,
  input  logic         advance,
  output logic [N-1:0] gnt
);
  localparam int PW = N > 1 ? $clog2(N) : 1;
  logic [PW-1:0] ptr_q, ptr_d;
  logic [2*N-1:0] req_dbl, gnt_dbl;
  logic [N-1:0] req_rot, gnt_rot;
  logic found;
  // Rotate so the highest-priority request sits at bit 0, pick the first, rotate back.
  assign req_dbl = {req & mask, req & mask} >> (int'(ptr_q) + 1);
  assign req_rot = req_dbl[N-1:0];
  assign gnt_dbl = {gnt_rot, gnt_rot} << (int'(ptr_q) + 1);
  assign gnt = gnt_dbl[2*N-1:N];
  always_comb begin
    gnt_rot = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!found && req_rot[i]) begin
        gnt_rot[i] = 1'b1;
        found = 1'b1;
      end
    end
  end
  always_comb begin
    ptr_d = ptr_q;
    for (int i = 0; i < N; i++) if (advance && gnt[i]) ptr_d = PW'(i);
  end
  always_ff @(posedge clk) begin
    if (rst) ptr_q <= PW'(N - 1);
    else ptr_q <= ptr_d;
  end
endmodule

// File: rtl/noc_credit_tx.sv
// noc_credit_tx: credit-based multi-VC link transmitter with packet-locked round-robin arbitration.
module noc_credit_tx import common_pkg::*; #(
  parameter int VC_W    = DEFAULT_VC_W,
  parameter int A_W     = DEFAULT_A_W,
  parameter int D_W     = DEFAULT_D_W,
  parameter int CREDITS = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [VC_W-1:0]             in_valid,
  output logic [VC_W-1:0]             in_ready,
  input  noc_packet_t [VC_W-1:0]      in_packet,
  output logic [VC_W-1:0]             out_vc_target,
  output noc_packet_t                 out_packet,
  input  logic [VC_W-1:0]             vc_credit_gnt,
  output logic [VC_W-1:0]             credit_avail,
  output logic                        credit_err
);
  localparam int CW = credit_cnt_w(CREDITS);
  localparam logic [CW-1:0] CMAX = CW'(CREDITS);
  arb_state_e state_q, state_d;
  logic [VC_W-1:0] lock_q, lock_d, elig, gnt, send;
  logic [VC_W-1:0] out_vc_target_q, out_vc_target_d;
  logic [VC_W-1:0][CW-1:0] cnt_q, cnt_d;
  noc_packet_t sel_pkt, out_packet_q, out_packet_d;
  logic credit_err_q, credit_err_d;
  assign elig = state_q == ST_LOCKED ? lock_q : '1;
  noc_rr_arbiter #(.N(VC_W)) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (in_valid & credit_avail),
    .mask    (elig),
    .advance (|send),
    .gnt     (gnt)
  );
  assign in_ready = rst ? '0 : gnt;
  assign send = in_ready & in_valid;
  assign out_vc_target = out_vc_target_q;
  assign out_packet = out_packet_q;
  assign credit_err = credit_err_q;
  always_comb begin
    sel_pkt = '0;
    for (int v = 0; v < VC_W; v++) begin
      credit_avail[v] = |cnt_q[v];
      if (send[v]) sel_pkt = in_packet[v];
    end
  end
  always_comb begin
    state_d = state_q;
    lock_d = lock_q;
    if (|send) begin
      state_d = sel_pkt.payload.last ? ST_IDLE : ST_LOCKED;
      lock_d = send;
    end
  end
  always_comb begin
    out_vc_target_d = send;
    out_packet_d = |send ? sel_pkt : out_packet_q;
  end
  // A grant that would push a full counter past CREDITS is dropped and flagged.
  always_comb begin
    credit_err_d = credit_err_q;
    for (int v = 0; v < VC_W; v++) begin
      cnt_d[v] = cnt_q[v] - CW'(send[v]) + CW'(vc_credit_gnt[v]);
      if (!send[v] && vc_credit_gnt[v] && cnt_q[v] == CMAX) begin
        cnt_d[v] = CMAX;
        credit_err_d = 1'b1;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      lock_q <= '0;
      cnt_q <= {VC_W{CMAX}};
      out_vc_target_q <= '0;
      out_packet_q <= '0;
      credit_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      lock_q <= lock_d;
      cnt_q <= cnt_d;
      out_vc_target_q <= out_vc_target_d;
      out_packet_q <= out_packet_d;
      credit_err_q <= credit_err_d;
    end
  end
`ifndef SYNTHESIS
  a_credits: assert property (@(posedge clk) CREDITS >= 1);
  a_pkt_w: assert property (@(posedge clk) $bits(noc_packet_t) == A_W + D_W + 1);
  a_rdy_1h: assert property (@(posedge clk) disable iff (rst) $onehot0(in_ready));
  a_tgt_1h: assert property (@(posedge clk) disable iff (rst) $onehot0(out_vc_target));
  a_no_uflow: assert property (@(posedge clk) disable iff (rst) (in_ready & ~credit_avail) == '0);
  a_no_x: assert property (@(posedge clk) disable iff (rst) !$isunknown({in_ready, out_vc_target}));
`endif
endmodule
